single_pulser: RTL and testbench

Converts a synchronized, debounced push-button level into exactly one clock-wide (or `PULSE_CYCLES`-wide) pulse per press. It sits downstream of the synchronizer/debouncer in the button-input chain. It feeds counters and FSMs that must act once per press regardless of how long the button is held.

---
 rtl/single_pulser_pkg.sv | 16 +
 rtl/single_pulser_if.sv | 9 +
 rtl/single_pulser.sv | 59 +++++
 tb/tb_single_pulser.sv | 107 ++++++++++
 4 files changed

// File: rtl/single_pulser_pkg.sv
// Shared types for the single-pulse generator: FSM state encoding and
// counter-width helper.
package single_pulser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PULSE = 2'b01,
    WAIT  = 2'b10
  } sp_state_e;

  // Enough bits to hold PULSE_CYCLES-1, and never fewer than one.
  function automatic int sp_cnt_w(input int pulse_cycles);
    return $clog2(pulse_cycles + 1);
  endfunction

endpackage

// File: rtl/single_pulser_if.sv
// Button-level in, single pulse out. The master drives the press level and
// the slave (the pulser) returns the pulse.
interface single_pulser_if;
  logic syncpress_i;
  logic SP_o;

  modport master (output syncpress_i, input  SP_o);
  modport slave  (input  syncpress_i, output SP_o);
endinterface

// File: rtl/single_pulser.sv
// Turns a synchronized press level into one PULSE_CYCLES-wide pulse per
// press. SP_o comes straight from a flop, so it has no combinational path from the input.
module single_pulser
  import single_pulser_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  single_pulser_if.slave  sp
);

  localparam int CW = sp_cnt_w(PULSE_CYCLES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(PULSE_CYCLES - 1);

  sp_state_e       state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            sp_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      sp_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sp_q  <= (state_nxt == PULSE);
    end
  end

  // The counter only carries a value while in PULSE; everywhere else it is zero.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    case (state)
      IDLE: begin
        if (sp.syncpress_i) begin
          state_nxt = PULSE;
          cnt_nxt   = CNT_LOAD;
        end
      end
      PULSE: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CW'(1);
        end else begin
          state_nxt = sp.syncpress_i ? WAIT : IDLE;
        end
      end
      WAIT: begin
        if (!sp.syncpress_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign sp.SP_o = sp_q;

endmodule

// File: tb/tb_single_pulser.sv
// Directed bench for single_pulser: two instances (PULSE_CYCLES 1 and 3),
// stimulus pushes hand-computed expectations, a monitor pops and compares.
module tb_single_pulser;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  single_pulser_if if1 ();
  single_pulser_if if3 ();

  single_pulser #(.PULSE_CYCLES(1)) u_dut1 (.clk(clk), .rst(rst), .sp(if1));
  single_pulser #(.PULSE_CYCLES(3)) u_dut3 (.clk(clk), .rst(rst), .sp(if3));

  typedef struct {
    logic e1;
    logic e3;
    int   idx;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   vectors     = 0;
  int   miscompares = 0;
  int   vidx        = 0;

  task automatic check(input string name, input logic act, input logic req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b", name, act, req);
    end
  endtask

  // Expected SP_o for the edge following each pushed vector.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      check($sformatf("dut1 vec%0d", mon_e.idx), if1.SP_o, mon_e.e1);
      check($sformatf("dut3 vec%0d", mon_e.idx), if3.SP_o, mon_e.e3);
    end
  end

  task automatic step(input logic rst_v, input logic in1, input logic e1,
                      input logic in3, input logic e3);
    exp_t e;
    @(negedge clk);
    rst             = rst_v;
    if1.syncpress_i = in1;
    if3.syncpress_i = in3;
    e.e1  = e1;
    e.e3  = e3;
    e.idx = vidx;
    vidx++;
    q.push_back(e);
  endtask

  task automatic seq(input string in1, input string e1,
                     input string in3, input string e3);
    for (int i = 0; i < in1.len(); i++)
      step(1'b1, in1[i] == "1", e1[i] == "1", in3[i] == "1", e3[i] == "1");
  endtask

  initial begin
    rst             = 1'b0;
    if1.syncpress_i = 1'b1;
    if3.syncpress_i = 1'b1;

    // Held in reset with the button down: no pulse.
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    // Release with the button down: counts as a fresh press; release early on dut3.
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    seq("0000", "0000", "0000", "1100");

    // dut1: long hold, re-press, fast toggle.
    seq("01110110010100", "01000100010100",
        "00000000000000", "00000000000000");

    // dut3: single-cycle press, 10-cycle hold, minimum re-arm spacing.
    seq("0000000000000000000000000", "0000000000000000000000000",
        "1000011111111110011101000", "1110011100000000011101110");

    // Async reset mid-pulse drops SP_o before the next edge.
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("async rst dut1", if1.SP_o, 1'b0);
    check("async rst dut3", if3.SP_o, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard drain: %0d left, expected 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
